// File: rtl/ram_arb_pkg.sv
// Shared defaults and helpers for the RAM port arbiter.
package ram_arb_pkg;

  localparam int unsigned DefNreq      = 2;
  localparam int unsigned DefAw        = 32;
  localparam int unsigned DefDw        = 32;
  localparam int unsigned DefRdLatency = 1;

  // Requester index width; a single-bit index is kept even for one requester.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int unsigned DefIdxW = idx_width(DefNreq);

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: grants the lowest requesting index at or after the pointer,
// wrapping modulo NREQ; the pointer moves one past each winner.
module rr_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NREQ = DefNreq,
  parameter int unsigned IW   = idx_width(NREQ)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [NREQ-1:0] req_i,
  output logic [NREQ-1:0] gnt_o,
  output logic [IW-1:0]   ptr_o
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic [IW-1:0] idx;
  logic          found;

  always_comb begin
    gnt_o = '0;
    ptr_d = ptr_q;
    idx   = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = IW'((32'(ptr_q) + k) % NREQ);
      if (!found && req_i[idx]) begin
        found      = 1'b1;
        gnt_o[idx] = 1'b1;
        ptr_d      = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
      end
    end
    // No grants may leak out while reset is asserted.
    if (!rst_ni) begin
      gnt_o = '0;
      ptr_d = ptr_q;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ptr_q <= '0;
    end else begin
      ptr_q <= ptr_d;
    end
  end

  assign ptr_o = ptr_q;

endmodule

// File: rtl/ram_port_arbiter.sv
// Shares one RAM read port and one RAM write port between NREQ requesters.
// Define RAM_ARB_PERF_EN to add per-requester stall counters.
module ram_port_arbiter
  import ram_arb_pkg::*;
#(
  parameter int unsigned NREQ       = DefNreq,
  parameter int unsigned AW         = DefAw,
  parameter int unsigned DW         = DefDw,
  parameter int unsigned RD_LATENCY = DefRdLatency
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_ren,
  input  logic [NREQ*AW-1:0] req_raddr,
  output logic [NREQ-1:0]   req_rgnt,
  output logic [NREQ-1:0]   rsp_rvalid,
  output logic [DW-1:0]     rsp_rdata,
  input  logic [NREQ-1:0]   req_wen,
  input  logic [NREQ*AW-1:0] req_waddr,
  input  logic [NREQ*DW-1:0] req_wdata,
  output logic [NREQ-1:0]   req_wgnt,
`ifdef RAM_ARB_PERF_EN
  output logic [NREQ*32-1:0] perf_rd_stall,
  output logic [NREQ*32-1:0] perf_wr_stall,
`endif
  output logic [AW-1:0]     ram_raddr_0,
  input  logic [DW-1:0]     ram_rdata_0,
  output logic [AW-1:0]     ram_waddr_0,
  output logic              ram_wen_0,
  output logic [DW-1:0]     ram_wdata_0
);

  localparam int unsigned IW = idx_width(NREQ);

  logic [IW-1:0] rd_ptr, wr_ptr;
  logic [IW-1:0] rd_idx;

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_rd_arb (
    .clk_i  (clk),
    .rst_ni (rst),
    .req_i  (req_ren),
    .gnt_o  (req_rgnt),
    .ptr_o  (rd_ptr)
  );

  rr_arbiter #(.NREQ(NREQ), .IW(IW)) u_wr_arb (
    .clk_i  (clk),
    .rst_ni (rst),
    .req_i  (req_wen),
    .gnt_o  (req_wgnt),
    .ptr_o  (wr_ptr)
  );

  // Pointers are only kept visible for debug probing.
  logic unused_ptr;
  assign unused_ptr = ^{rd_ptr, wr_ptr};

  always_comb begin
    rd_idx      = '0;
    ram_raddr_0 = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_rgnt[i]) begin
        rd_idx      = IW'(i);
        ram_raddr_0 = req_raddr[i*AW +: AW];
      end
    end
  end

  always_comb begin
    ram_waddr_0 = '0;
    ram_wdata_0 = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req_wgnt[i]) begin
        ram_waddr_0 = req_waddr[i*AW +: AW];
        ram_wdata_0 = req_wdata[i*DW +: DW];
      end
    end
  end

  assign ram_wen_0 = |req_wgnt;

  // Tag pipeline tracks which requester owns the RAM data RD_LATENCY cycles later.
  logic [RD_LATENCY-1:0] tag_vld_q;
  logic [IW-1:0]         tag_idx_q [RD_LATENCY];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tag_vld_q <= '0;
      for (int unsigned i = 0; i < RD_LATENCY; i++) begin
        tag_idx_q[i] <= '0;
      end
    end else begin
      tag_vld_q[0] <= |req_rgnt;
      tag_idx_q[0] <= rd_idx;
      for (int unsigned i = 1; i < RD_LATENCY; i++) begin
        tag_vld_q[i] <= tag_vld_q[i-1];
        tag_idx_q[i] <= tag_idx_q[i-1];
      end
    end
  end

  always_comb begin
    rsp_rvalid = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      rsp_rvalid[i] = tag_vld_q[RD_LATENCY-1] && (tag_idx_q[RD_LATENCY-1] == IW'(i));
    end
  end

  assign rsp_rdata = ram_rdata_0;

`ifdef RAM_ARB_PERF_EN
  logic [31:0] rd_stall_q [NREQ];
  logic [31:0] wr_stall_q [NREQ];

  // Saturating counts of cycles spent requesting without a grant.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        rd_stall_q[i] <= '0;
        wr_stall_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (req_ren[i] && !req_rgnt[i] && (rd_stall_q[i] != '1)) begin
          rd_stall_q[i] <= rd_stall_q[i] + 32'd1;
        end
        if (req_wen[i] && !req_wgnt[i] && (wr_stall_q[i] != '1)) begin
          wr_stall_q[i] <= wr_stall_q[i] + 32'd1;
        end
      end
    end
  end

  always_comb begin
    perf_rd_stall = '0;
    perf_wr_stall = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      perf_rd_stall[i*32 +: 32] = rd_stall_q[i];
      perf_wr_stall[i*32 +: 32] = wr_stall_q[i];
    end
  end
`endif

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a small RAM stub of matching read latency.
module tb_ram_port_arbiter;

  localparam int unsigned NREQ  = 2;
  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 16;
  localparam int unsigned RdLat = 3;

  logic                clk = 1'b0;
  logic                rst;
  logic [NREQ-1:0]     req_ren, req_rgnt, rsp_rvalid, req_wen, req_wgnt;
  logic [NREQ*AW-1:0]  req_raddr, req_waddr;
  logic [NREQ*DW-1:0]  req_wdata;
  logic [DW-1:0]       rsp_rdata, ram_rdata_0, ram_wdata_0;
  logic [AW-1:0]       ram_raddr_0, ram_waddr_0;
  logic                ram_wen_0;
`ifdef RAM_ARB_PERF_EN
  logic [NREQ*32-1:0]  perf_rd_stall, perf_wr_stall;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  ram_port_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .RD_LATENCY(RdLat)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_ren     (req_ren),
    .req_raddr   (req_raddr),
    .req_rgnt    (req_rgnt),
    .rsp_rvalid  (rsp_rvalid),
    .rsp_rdata   (rsp_rdata),
    .req_wen     (req_wen),
    .req_waddr   (req_waddr),
    .req_wdata   (req_wdata),
    .req_wgnt    (req_wgnt),
`ifdef RAM_ARB_PERF_EN
    .perf_rd_stall (perf_rd_stall),
    .perf_wr_stall (perf_wr_stall),
`endif
    .ram_raddr_0 (ram_raddr_0),
    .ram_rdata_0 (ram_rdata_0),
    .ram_waddr_0 (ram_waddr_0),
    .ram_wen_0   (ram_wen_0),
    .ram_wdata_0 (ram_wdata_0)
  );

  // RAM stub: mem[a] starts as 0x100+a, read data appears RdLat cycles after the address.
  logic [DW-1:0] mem [256];
  logic [DW-1:0] rd_pipe [RdLat];
  logic          mem_ready = 1'b0;

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 16'(32'h100 + i);
      mem_ready <= 1'b1;
    end else if (ram_wen_0) begin
      mem[ram_waddr_0] <= ram_wdata_0;
    end
    rd_pipe[0] <= mem[ram_raddr_0];
    for (int k = 1; k < RdLat; k++) rd_pipe[k] <= rd_pipe[k-1];
  end

  assign ram_rdata_0 = rd_pipe[RdLat-1];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  logic [1:0]  exp_g, exp_v;
  logic [15:0] exp_d;

  initial begin
    rst       = 1'b0;
    req_ren   = 2'b11;
    req_raddr = {8'd5, 8'd4};
    req_wen   = 2'b00;
    req_waddr = '0;
    req_wdata = '0;

    // Reset holds everything quiet even with requests pending.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_eq("rst_rgnt", req_rgnt, 2'b00);
    check_eq("rst_wgnt", req_wgnt, 2'b00);
    check_eq("rst_rvalid", rsp_rvalid, 2'b00);
    check_eq("rst_wen", ram_wen_0, 1'b0);
`ifdef RAM_ARB_PERF_EN
    check_eq("rst_perf_rd", perf_rd_stall, 64'd0);
    check_eq("rst_perf_wr", perf_wr_stall, 64'd0);
`endif
    step();
    rst = 1'b1;
    @(negedge clk);
    check_eq("rel_rgnt", req_rgnt, 2'b01);
    check_eq("rel_raddr", ram_raddr_0, 8'd4);
    step();
    req_ren = 2'b00;
    step();
    step();
    @(negedge clk);
    check_eq("rel_rvalid", rsp_rvalid, 2'b01);
    check_eq("rel_rdata", rsp_rdata, 16'h104);

    // Write addr 10 from req0, then read it back from req1 the next cycle.
    step();
    req_wen   = 2'b01;
    req_waddr = {8'd0, 8'd10};
    req_wdata = {16'd0, 16'd15};
    @(negedge clk);
    check_eq("wr_wgnt", req_wgnt, 2'b01);
    check_eq("wr_wen", ram_wen_0, 1'b1);
    check_eq("wr_waddr", ram_waddr_0, 8'd10);
    check_eq("wr_wdata", ram_wdata_0, 16'd15);
    step();
    req_wen   = 2'b00;
    req_ren   = 2'b10;
    req_raddr = {8'd10, 8'd0};
    @(negedge clk);
    check_eq("rd_rgnt", req_rgnt, 2'b10);
    check_eq("rd_wen_idle", ram_wen_0, 1'b0);
    step();
    req_ren = 2'b00;
    step();
    @(negedge clk);
    check_eq("rd_early", rsp_rvalid, 2'b00);
    step();
    @(negedge clk);
    check_eq("rd_rvalid", rsp_rvalid, 2'b10);
    check_eq("rd_rdata", rsp_rdata, 16'd15);

    // Contention: both read for 4 cycles, grants and responses alternate.
    req_raddr = {8'd13, 8'd12};
    for (int c = 0; c < 7; c++) begin
      step();
      req_ren = (c < 4) ? 2'b11 : 2'b00;
      @(negedge clk);
      exp_g = (c >= 4) ? 2'b00 : ((c % 2 == 0) ? 2'b01 : 2'b10);
      exp_v = (c < 3) ? 2'b00 : (((c - 3) % 2 == 0) ? 2'b01 : 2'b10);
      check_eq("ct_rgnt", req_rgnt, exp_g);
      check_eq("ct_rvalid", rsp_rvalid, exp_v);
      if (c >= 3) begin
        exp_d = ((c - 3) % 2 == 0) ? 16'h10C : 16'h10D;
        check_eq("ct_rdata", rsp_rdata, exp_d);
      end
    end

    // Independent ports in the same cycle.
    step();
    req_ren   = 2'b01;
    req_raddr = {8'd0, 8'd12};
    req_wen   = 2'b10;
    req_waddr = {8'd20, 8'd0};
    req_wdata = {16'hBEEF, 16'd0};
    @(negedge clk);
    check_eq("ind_rgnt", req_rgnt, 2'b01);
    check_eq("ind_wgnt", req_wgnt, 2'b10);
    check_eq("ind_raddr", ram_raddr_0, 8'd12);
    check_eq("ind_waddr", ram_waddr_0, 8'd20);
    check_eq("ind_wdata", ram_wdata_0, 16'hBEEF);
    step();
    req_ren = 2'b00;
    req_wen = 2'b00;
    step();
    step();
    @(negedge clk);
    check_eq("ind_rvalid", rsp_rvalid, 2'b01);
    check_eq("ind_rdata", rsp_rdata, 16'h10C);

`ifdef RAM_ARB_PERF_EN
    // req1 loses three write arbitrations to req0; req0 never waits.
    req_waddr = {8'd31, 8'd30};
    for (int r = 0; r < 3; r++) begin
      step();
      req_wen = 2'b11;
      @(negedge clk);
      check_eq("pf_wgnt_a", req_wgnt, 2'b01);
      step();
      req_wen = 2'b10;
      @(negedge clk);
      check_eq("pf_wgnt_b", req_wgnt, 2'b10);
    end
    step();
    req_wen = 2'b00;
    @(negedge clk);
    check_eq("pf_wr_stall", perf_wr_stall, {32'd3, 32'd0});
    check_eq("pf_rd_stall", perf_rd_stall, {32'd3, 32'd2});
`endif

    // Reset one cycle after a read grant: that response must never appear.
    step();
    req_ren   = 2'b01;
    req_raddr = {8'd0, 8'd12};
    @(negedge clk);
    check_eq("mf_rgnt", req_rgnt, 2'b01);
    step();
    req_ren   = 2'b00;
    req_wen   = 2'b01;
    req_waddr = {8'd0, 8'd40};
    rst       = 1'b0;
    @(negedge clk);
    check_eq("mf_wen_rst", ram_wen_0, 1'b0);
    check_eq("mf_wgnt_rst", req_wgnt, 2'b00);
    step();
    rst     = 1'b1;
    req_wen = 2'b00;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      check_eq("mf_rvalid", rsp_rvalid, 2'b00);
      step();
    end
    req_ren = 2'b10;
    @(negedge clk);
    check_eq("mf_alive_rgnt", req_rgnt, 2'b10);
    step();
    req_ren = 2'b00;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ram_port_arbiter.md
Name: ram_port_arbiter

Overview:
- Shares the two RAM ports (`raddr_0`/`rdata_0` read, `waddr_0`/`wen_0`/`wdata_0` write) between NREQ kernel-style requesters, e.g. several `read_write_ram` instances.
- Read and write ports are arbitrated independently, each round-robin.
- Read data is routed back to the winning requester after the fixed RAM read latency.
- Sits between the kernels and the RAM, replacing direct kernel-to-RAM wiring.

Parameters:
- NREQ, 2, number of requesters (2..8).
- AW, 32, address width.
- DW, 32, data width.
- RD_LATENCY, 1, RAM read latency in cycles, from `ram_raddr_0` valid to `ram_rdata_0` valid (>=1).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-low.
- req_ren  in  NREQ  per-requester read request; held until granted.
- req_raddr  in  NREQ*AW  read addresses; requester i occupies slice [i*AW +: AW].
- req_rgnt  out  NREQ  read grant, one-hot or zero, combinational in the request cycle.
- rsp_rvalid  out  NREQ  read data valid for requester i.
- rsp_rdata  out  DW  read data, shared by all requesters, qualified by rsp_rvalid.
- req_wen  in  NREQ  per-requester write request; held until granted.
- req_waddr  in  NREQ*AW  write addresses.
- req_wdata  in  NREQ*DW  write data.
- req_wgnt  out  NREQ  write grant, one-hot or zero, combinational.
- ram_raddr_0  out  AW  RAM read address.
- ram_rdata_0  in  DW  RAM read data.
- ram_waddr_0  out  AW  RAM write address.
- ram_wen_0  out  1  RAM write enable.
- ram_wdata_0  out  DW  RAM write data.

Behaviour:
- Reset (`rst`=0, async): read and write RR pointers go to 0; the read-tag pipeline clears; `rsp_rvalid`=0; `ram_wen_0`=0; grants are 0 while in reset.
- Arbitration, per port, per cycle: grant the lowest index >= ptr with an active request, wrapping modulo NREQ.
  - On a grant to i, ptr <= (i+1) mod NREQ.
  - With no request, ptr holds and the grant is 0.
  - Read and write arbiters are fully independent; one requester may win both ports in the same cycle.
- Read path:
  - `ram_raddr_0` = `req_raddr` slice of the read winner; 0 when there is no grant.
  - A valid+index tag enters a RD_LATENCY-deep shift pipeline.
  - `rsp_rvalid[i]`=1 exactly RD_LATENCY cycles after the grant cycle; `rsp_rdata` = `ram_rdata_0` passed through combinationally.
  - Back-to-back grants give back-to-back responses in grant order; throughput is one read per cycle.
- Write path:
  - `ram_wen_0` = OR of `req_wgnt`; `ram_waddr_0`/`ram_wdata_0` = winner's slices, 0 when idle.
  - A write is committed in its grant cycle.
- Ordering:
  - A write granted in cycle N is visible to any read granted in cycle N+1 or later.
  - A same-cycle read and write to the same address returns RAM-defined data; the arbiter performs no forwarding.
- Fairness: a requester held continuously is granted within NREQ cycles on each port.
- Request dropped before grant: legal; nothing is issued.
- Reset mid-operation: in-flight read tags are discarded and no `rsp_rvalid` appears after reset release; a RAM write in the reset cycle is suppressed.
- `req_rgnt`/`req_wgnt` are never asserted for a bit whose request is low.

Optional Feature:
- Macro: RAM_ARB_PERF_EN.
- Defined:
  - Adds outputs `perf_rd_stall` (NREQ*32) and `perf_wr_stall` (NREQ*32).
  - Per requester, counts cycles with request high and grant low.
  - Counters saturate at 2^32-1 and reset to 0.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package `ram_arb_pkg`: default NREQ/AW/DW, the RD_LATENCY default, and the index width localparam (clog2 of NREQ, minimum 1).
- Sub-module `rr_arbiter` (params NREQ):
  - Inputs: req vector.
  - Outputs: one-hot gnt, plus the registered pointer.
  - Instantiated twice, once for the read port and once for the write port.

Test Plan:
- Reset: hold `rst`=0 with `req_ren`=2'b11 -> grants 0, `rsp_rvalid`=0, `ram_wen_0`=0; release -> first read grant 2'b01.
- Single write then read:
  - Req0 writes addr 10 data 15 in cycle N -> `ram_wen_0`=1, `ram_waddr_0`=10.
  - Req1 reads addr 10 in N+1 -> `rsp_rvalid`=2'b10 at N+1+RD_LATENCY, `rsp_rdata`=15.
- Contention: both requesters hold `req_ren` for 4 cycles (addr 12 / addr 13) -> grants alternate 01,10,01,10; responses return in the same order, each RD_LATENCY later.
- Independent ports: req0 reads and req1 writes in the same cycle -> both granted that cycle; read data is unaffected by a write to another address.
- Mid-flight reset: grant a read with RD_LATENCY=3, assert `rst` one cycle later -> no `rsp_rvalid` ever appears for that read.
- With RAM_ARB_PERF_EN: req1 blocked 3 cycles by req0 priority on writes -> `perf_wr_stall[1]`=3 and `perf_wr_stall[0]`=0.
